// File: rtl/urna_pkg.sv
// Shared definitions for the ballot-box vote-collection core: FSM state
// encoding, default candidate code table and readout-index offsets.
package urna_pkg;

    typedef enum logic [2:0] {
        ENTRY0  = 3'd0,
        ENTRY1  = 3'd1,
        ENTRY2  = 3'd2,
        COMMIT  = 3'd3,
        TALLY   = 3'd4,
        RESULTS = 3'd5
    } urna_state_t;

    // Four candidates: index 0 = 10, 1 = 13, 2 = 17, 3 = 51 (BCD)
    localparam logic [31:0] DEFAULT_CAND_CODES = {8'h51, 8'h17, 8'h13, 8'h10};

    // Readout selects beyond the candidate range are offsets from N_CAND
    localparam int RD_NULL  = 0;
    localparam int RD_TOTAL = 1;
    localparam int RD_BLANK = 2;

endpackage

// File: rtl/urna_sat_counter.sv
// Saturating vote counter. Holds at all-ones; a sticky ovf flag records
// that an increment arrived while already saturated (a lost vote).
module urna_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_reg;
    logic             ovf_reg;

    // Increment until saturated, then flag every further increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (inc) begin
            if (count_reg == CNT_MAX) begin
                ovf_reg <= 1'b1;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign count = count_reg;
    assign ovf   = ovf_reg;

endmodule

// File: rtl/urna_core_param.sv
// Vote-collection core: two-digit BCD entry, per-candidate/null/total
// tallies, sequential winner scan and a registered readout port.
// Optional blank-vote support is compiled in with URNA_BLANK_VOTE_EN.
module urna_core_param
    import urna_pkg::*;
#(
    parameter int                  N_CAND     = 4,
    parameter int                  CNT_W      = 8,
    parameter logic [N_CAND*8-1:0] CAND_CODES = DEFAULT_CAND_CODES,
    localparam int                 RD_W       = $clog2(N_CAND + 3),
    localparam int                 WIN_W      = $clog2(N_CAND)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             digit_vld,
    input  logic [3:0]       digit,
    input  logic             correct_i,
    input  logic             confirm_i,
    input  logic             finalize_i,
`ifdef URNA_BLANK_VOTE_EN
    input  logic             blank_i,
`endif
    input  logic [RD_W-1:0]  rd_idx,
    output logic [2:0]       state_o,
    output logic [3:0]       dig_hi,
    output logic [3:0]       dig_lo,
    output logic             vote_ack,
    output logic [CNT_W-1:0] rd_count,
    output logic             results_vld,
    output logic [WIN_W-1:0] winner_idx,
    output logic             tie,
    output logic             ovf
);

    localparam int SCAN_W = $clog2(N_CAND + 1);

    urna_state_t       state_reg, state_next;
    logic [3:0]        dig_hi_reg, dig_lo_reg;
    logic              digit_ok, in_entry, commit, commit_blank;
    logic [SCAN_W-1:0] scan_reg;
    logic [CNT_W-1:0]  best_reg, scan_cnt;
    logic [WIN_W-1:0]  best_idx_reg;
    logic              tie_reg;
    logic [CNT_W-1:0]  rd_next, rd_count_reg;

    logic [CNT_W-1:0]  cnt [N_CAND];
    logic [N_CAND-1:0] cand_inc, cand_ovf;
    logic [CNT_W-1:0]  null_cnt, total_cnt;
    logic              null_ovf, total_ovf;

    assign digit_ok = digit_vld && (digit <= 4'd9);
    assign in_entry = (state_reg == ENTRY0) || (state_reg == ENTRY1) || (state_reg == ENTRY2);
    assign commit   = (state_reg == COMMIT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ENTRY0;
        else        state_reg <= state_next;
    end

    // Next state: finalize > correct > blank > confirm > digit while entering
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ENTRY0, ENTRY1, ENTRY2: begin
                if (finalize_i)                                 state_next = TALLY;
                else if (correct_i)                             state_next = ENTRY0;
`ifdef URNA_BLANK_VOTE_EN
                else if (blank_i && state_reg == ENTRY0)        state_next = COMMIT;
`endif
                else if (confirm_i && state_reg == ENTRY2)      state_next = COMMIT;
                else if (digit_ok && state_reg == ENTRY0)       state_next = ENTRY1;
                else if (digit_ok && state_reg == ENTRY1)       state_next = ENTRY2;
            end
            COMMIT:  state_next = ENTRY0;
            TALLY:   if (scan_reg == SCAN_W'(N_CAND)) state_next = RESULTS;
            RESULTS: state_next = RESULTS;
            default: state_next = ENTRY0;
        endcase
    end

    // FSM outputs decoded directly from the current state
    always_comb begin
        vote_ack    = (state_reg == COMMIT);
        results_vld = (state_reg == RESULTS);
    end

    // Digit capture; cleared on correct, finalize and after each commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_hi_reg <= 4'd0;
            dig_lo_reg <= 4'd0;
        end else if ((in_entry && (finalize_i || correct_i)) || commit) begin
            dig_hi_reg <= 4'd0;
            dig_lo_reg <= 4'd0;
        end else if (state_reg == ENTRY0 && state_next == ENTRY1) begin
            dig_hi_reg <= digit;
        end else if (state_reg == ENTRY1 && state_next == ENTRY2) begin
            dig_lo_reg <= digit;
        end
    end

    // One counter per candidate, incremented on a code match during COMMIT
    generate
        for (genvar gi = 0; gi < N_CAND; gi++) begin : g_cand
            assign cand_inc[gi] = commit && !commit_blank &&
                                  ({dig_hi_reg, dig_lo_reg} == CAND_CODES[8*gi +: 8]);
            urna_sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (cand_inc[gi]),
                .count (cnt[gi]),
                .ovf   (cand_ovf[gi])
            );
        end
    endgenerate

    urna_sat_counter #(.CNT_W(CNT_W)) u_null (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (commit && !commit_blank && (cand_inc == '0)),
        .count (null_cnt),
        .ovf   (null_ovf)
    );

    urna_sat_counter #(.CNT_W(CNT_W)) u_total (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (commit),
        .count (total_cnt),
        .ovf   (total_ovf)
    );

`ifdef URNA_BLANK_VOTE_EN
    logic [CNT_W-1:0] blank_cnt;
    logic             blank_ovf, commit_blank_reg;

    // Remember that the coming COMMIT was entered through the blank key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) commit_blank_reg <= 1'b0;
        else        commit_blank_reg <= (state_reg == ENTRY0) && (state_next == COMMIT);
    end

    assign commit_blank = commit_blank_reg;

    urna_sat_counter #(.CNT_W(CNT_W)) u_blank (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (commit && commit_blank),
        .count (blank_cnt),
        .ovf   (blank_ovf)
    );

    assign ovf = (|cand_ovf) | null_ovf | total_ovf | blank_ovf;
`else
    assign commit_blank = 1'b0;
    assign ovf          = (|cand_ovf) | null_ovf | total_ovf;
`endif

    // Counter value under the scan pointer (zero once past the last one)
    always_comb begin
        scan_cnt = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (scan_reg == SCAN_W'(i)) scan_cnt = cnt[i];
        end
    end

    // Winner scan: one candidate per cycle, results frozen after the scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_reg     <= '0;
            best_reg     <= '0;
            best_idx_reg <= '0;
            tie_reg      <= 1'b0;
        end else if (state_reg != TALLY && state_next == TALLY) begin
            scan_reg     <= '0;
            best_reg     <= '0;
            best_idx_reg <= '0;
            tie_reg      <= 1'b1;
        end else if (state_reg == TALLY && scan_reg != SCAN_W'(N_CAND)) begin
            if (scan_cnt > best_reg) begin
                best_reg     <= scan_cnt;
                best_idx_reg <= scan_reg[WIN_W-1:0];
                tie_reg      <= 1'b0;
            end else if (scan_cnt == best_reg) begin
                tie_reg <= 1'b1;
            end
            scan_reg <= scan_reg + 1'b1;
        end
    end

    // Readout select: candidates, then null, total, blank; anything else reads 0
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (rd_idx == RD_W'(i)) rd_next = cnt[i];
        end
        if (rd_idx == RD_W'(N_CAND + RD_NULL))  rd_next = null_cnt;
        if (rd_idx == RD_W'(N_CAND + RD_TOTAL)) rd_next = total_cnt;
`ifdef URNA_BLANK_VOTE_EN
        if (rd_idx == RD_W'(N_CAND + RD_BLANK)) rd_next = blank_cnt;
`endif
    end

    // Registered readout, one cycle behind rd_idx
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_count_reg <= '0;
        else        rd_count_reg <= rd_next;
    end

    assign state_o    = state_reg;
    assign dig_hi     = dig_hi_reg;
    assign dig_lo     = dig_lo_reg;
    assign rd_count   = rd_count_reg;
    assign winner_idx = best_idx_reg;
    assign tie        = tie_reg;

endmodule

// File: tb/tb_urna_core_param.sv
// Directed bench for urna_core_param: a table of votes with cumulative
// expected counters, plus hand-written sequences for finalize timing,
// ties, pulse priority, saturation (second instance, CNT_W=2) and reset.
module tb_urna_core_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       digit_vld;
    logic [3:0] digit;
    logic       correct_i, confirm_i, finalize_i;
    logic [2:0] rd_idx;
`ifdef URNA_BLANK_VOTE_EN
    logic       blank_i;
`endif

    logic [2:0] state_o, state_o2;
    logic [3:0] dig_hi, dig_lo, dig_hi2, dig_lo2;
    logic       vote_ack, vote_ack2, results_vld, results_vld2;
    logic [7:0] rd_count;
    logic [1:0] rd_count2;
    logic [1:0] winner_idx, winner_idx2;
    logic       tie, tie2, ovf, ovf2;

    int n_cmp  = 0;
    int n_fail = 0;

    initial forever #5 clk = ~clk;

    urna_core_param dut (
        .clk (clk), .rst_n (rst_n), .digit_vld (digit_vld), .digit (digit),
        .correct_i (correct_i), .confirm_i (confirm_i), .finalize_i (finalize_i),
`ifdef URNA_BLANK_VOTE_EN
        .blank_i (blank_i),
`endif
        .rd_idx (rd_idx), .state_o (state_o), .dig_hi (dig_hi), .dig_lo (dig_lo),
        .vote_ack (vote_ack), .rd_count (rd_count), .results_vld (results_vld),
        .winner_idx (winner_idx), .tie (tie), .ovf (ovf)
    );

    urna_core_param #(.CNT_W(2)) dut2 (
        .clk (clk), .rst_n (rst_n), .digit_vld (digit_vld), .digit (digit),
        .correct_i (correct_i), .confirm_i (confirm_i), .finalize_i (finalize_i),
`ifdef URNA_BLANK_VOTE_EN
        .blank_i (blank_i),
`endif
        .rd_idx (rd_idx), .state_o (state_o2), .dig_hi (dig_hi2), .dig_lo (dig_lo2),
        .vote_ack (vote_ack2), .rd_count (rd_count2), .results_vld (results_vld2),
        .winner_idx (winner_idx2), .tie (tie2), .ovf (ovf2)
    );

    typedef struct {
        logic [3:0] hi;
        logic [3:0] lo;
        logic [2:0] rd;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        digit_vld = 1'b0; digit = 4'd0;
        correct_i = 1'b0; confirm_i = 1'b0; finalize_i = 1'b0;
        rd_idx = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic key(input logic [3:0] d);
        @(negedge clk);
        digit = d; digit_vld = 1'b1;
        @(negedge clk);
        digit_vld = 1'b0;
    endtask

    task automatic pulse_ctl(input logic c, input logic f, input logic cf);
        @(negedge clk);
        correct_i = c; finalize_i = f; confirm_i = cf;
        @(negedge clk);
        correct_i = 1'b0; finalize_i = 1'b0; confirm_i = 1'b0;
    endtask

    // ack: vote_ack in the COMMIT cycle; ack_next: one cycle later
    task automatic vote(input logic [3:0] hi, input logic [3:0] lo,
                        output logic ack, output logic ack_next);
        key(hi);
        key(lo);
        @(negedge clk);
        confirm_i = 1'b1;
        @(negedge clk);
        confirm_i = 1'b0;
        ack = vote_ack;
        @(negedge clk);
        ack_next = vote_ack;
    endtask

    task automatic read(input logic [2:0] idx, output logic [7:0] v, output logic [1:0] v2);
        @(negedge clk);
        rd_idx = idx;
        @(negedge clk);
        v  = rd_count;
        v2 = rd_count2;
    endtask

    // Cycles from the edge sampling finalize_i to the edge raising results_vld
    task automatic finalize_wait(output int cycles);
        @(negedge clk);
        finalize_i = 1'b1;
        @(posedge clk);
        #1 finalize_i = 1'b0;
        cycles = 0;
        while (results_vld !== 1'b1 && cycles < 50) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        vec_t       vecs [11];
        logic       ack, ack_n;
        logic [7:0] v;
        logic [1:0] v2;
        int         cyc;

        // Cumulative from reset: codes 10,13,17,51 -> idx 0..3; rd 4=null 5=total 6=blank 7=none
        vecs[0]  = '{4'd1, 4'd0, 3'd0, 8'd1};
        vecs[1]  = '{4'd9, 4'd9, 3'd4, 8'd1};
        vecs[2]  = '{4'd1, 4'd3, 3'd1, 8'd1};
        vecs[3]  = '{4'd5, 4'd1, 3'd3, 8'd1};
        vecs[4]  = '{4'd1, 4'd7, 3'd2, 8'd1};
        vecs[5]  = '{4'd0, 4'd0, 3'd4, 8'd2};
        vecs[6]  = '{4'd1, 4'd3, 3'd1, 8'd2};
        vecs[7]  = '{4'd1, 4'd3, 3'd5, 8'd8};
        vecs[8]  = '{4'd1, 4'd0, 3'd0, 8'd2};
        vecs[9]  = '{4'd4, 4'd2, 3'd6, 8'd0};
        vecs[10] = '{4'd1, 4'd3, 3'd7, 8'd0};

`ifdef URNA_BLANK_VOTE_EN
        blank_i = 1'b0;
`endif
        do_reset();

        check("reset_state", state_o, 0);
        check("reset_dig_hi", dig_hi, 0);
        check("reset_dig_lo", dig_lo, 0);
        check("reset_vote_ack", vote_ack, 0);
        check("reset_rd_count", rd_count, 0);
        check("reset_results_vld", results_vld, 0);
        check("reset_winner", winner_idx, 0);
        check("reset_tie", tie, 0);
        check("reset_ovf", ovf, 0);

        // Digit entry, ignored keys, correction
        key(4'd1);
        check("entry_dig_hi", dig_hi, 1);
        check("entry_state1", state_o, 1);
        key(4'hC);
        check("digit_gt9_state", state_o, 1);
        check("digit_gt9_dig_lo", dig_lo, 0);
        pulse_ctl(1'b0, 1'b0, 1'b1);
        check("confirm_entry1_state", state_o, 1);
        pulse_ctl(1'b1, 1'b0, 1'b0);
        check("correct_state", state_o, 0);
        check("correct_dig_hi", dig_hi, 0);
        key(4'd5);
        key(4'd1);
        key(4'd7);
        check("entry2_extra_dig_lo", dig_lo, 1);
        check("entry2_state", state_o, 2);
        @(negedge clk);
        confirm_i = 1'b1;
        @(negedge clk);
        confirm_i = 1'b0;
        check("commit_state", state_o, 3);
        check("commit_ack", vote_ack, 1);
        read(3'd3, v, v2);
        check("corrected_vote_cnt3", v, 1);
        read(3'd4, v, v2);
        check("corrected_vote_null", v, 0);

        // Table of votes with cumulative readback
        do_reset();
        for (int i = 0; i < 11; i++) begin
            vote(vecs[i].hi, vecs[i].lo, ack, ack_n);
            read(vecs[i].rd, v, v2);
            $display("vec %0d: vote %0d%0d, rd_idx %0d -> %0d (exp %0d)",
                     i, vecs[i].hi, vecs[i].lo, vecs[i].rd, v, vecs[i].exp);
            check($sformatf("vec%0d_ack", i), ack, 1);
            check($sformatf("vec%0d_ack_len", i), ack_n, 0);
            check($sformatf("vec%0d_rd", i), v, vecs[i].exp);
        end

        // Finalize: cnt = {2,4,1,1} -> winner 1, no tie
        finalize_wait(cyc);
        check("finalize_latency", cyc, 5);
        check("results_state", state_o, 5);
        check("results_winner", winner_idx, 1);
        check("results_tie", tie, 0);
        vote(4'd1, 4'd0, ack, ack_n);
        check("results_ignores_vote_ack", ack, 0);
        check("results_stays", state_o, 5);
        read(3'd5, v, v2);
        check("results_total_frozen", v, 11);

        // Two-way tie: codes 10 and 17 twice each
        do_reset();
        vote(4'd1, 4'd0, ack, ack_n);
        vote(4'd1, 4'd0, ack, ack_n);
        vote(4'd1, 4'd7, ack, ack_n);
        vote(4'd1, 4'd7, ack, ack_n);
        finalize_wait(cyc);
        check("tie2_latency", cyc, 5);
        check("tie2_tie", tie, 1);
        check("tie2_winner", winner_idx, 0);

        // No votes at all
        do_reset();
        finalize_wait(cyc);
        check("empty_tie", tie, 1);
        check("empty_winner", winner_idx, 0);

        // finalize wins over confirm in ENTRY2
        do_reset();
        key(4'd1);
        key(4'd0);
        @(negedge clk);
        confirm_i = 1'b1; finalize_i = 1'b1;
        @(negedge clk);
        confirm_i = 1'b0; finalize_i = 1'b0;
        check("fin_confirm_state", state_o, 4);
        check("fin_confirm_ack", vote_ack, 0);
        read(3'd5, v, v2);
        check("fin_confirm_total", v, 0);

        // Saturation on the CNT_W=2 instance
        do_reset();
        vote(4'd1, 4'd0, ack, ack_n);
        vote(4'd1, 4'd0, ack, ack_n);
        check("sat_ovf_early", ovf2, 0);
        vote(4'd1, 4'd0, ack, ack_n);
        vote(4'd1, 4'd0, ack, ack_n);
        vote(4'd1, 4'd0, ack, ack_n);
        read(3'd0, v, v2);
        check("sat_cnt0_w2", v2, 3);
        check("sat_cnt0_w8", v, 5);
        read(3'd5, v, v2);
        check("sat_total_w2", v2, 3);
        check("sat_ovf_w2", ovf2, 1);
        check("sat_ovf_w8", ovf, 0);

        // Asynchronous reset in the middle of a COMMIT
        do_reset();
        key(4'd1);
        key(4'd0);
        @(negedge clk);
        confirm_i = 1'b1;
        @(negedge clk);
        confirm_i = 1'b0;
        check("midcommit_ack", vote_ack, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_state", state_o, 0);
        check("async_reset_ack", vote_ack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        read(3'd5, v, v2);
        check("midcommit_total_lost", v, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/urna_core_param.md
# urna_core_param

Parametrised, fully synchronous vote-collection core for the electronic ballot box. It accepts pre-debounced single-cycle key pulses, assembles a two-digit BCD candidate code, and tallies votes per candidate, null and total. On finalisation it scans the counters sequentially to find the winner. It sits between the key/digit front end and the LCD/HEX display logic, which reads results through a registered readout port.

## Interface
Parameters:
- N_CAND, 4, number of candidates (2..16)
- CNT_W, 8, width of every vote counter
- CAND_CODES, {8'h51,8'h17,8'h13,8'h10}, packed N_CAND×8 BCD codes; entry i occupies bits [8i+7:8i]

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- digit_vld  in  1  single-cycle pulse, digit present
- digit  in  4  BCD digit; values >9 ignored
- correct_i  in  1  pulse, clear partial entry
- confirm_i  in  1  pulse, cast vote
- finalize_i  in  1  pulse, close voting
- rd_idx  in  clog2(N_CAND+3)  readout select
- state_o  out  3  current state encoding
- dig_hi, dig_lo  out  4 each  entered digits (0 when absent)
- vote_ack  out  1  one-cycle pulse per committed vote
- rd_count  out  CNT_W  registered counter selected by rd_idx
- results_vld  out  1  high in RESULTS
- winner_idx  out  clog2(N_CAND)  winning candidate index
- tie  out  1  no unique winner
- ovf  out  1  sticky: any counter saturated

## Operation
- States: ENTRY0=0, ENTRY1=1, ENTRY2=2, COMMIT=3, TALLY=4, RESULTS=5.
- ENTRY0: valid digit → dig_hi, go ENTRY1. ENTRY1: valid digit → dig_lo, go ENTRY2. ENTRY2: further digits ignored.
- confirm_i honoured only in ENTRY2 → COMMIT; ignored in ENTRY0/ENTRY1.
- correct_i in ENTRY1/ENTRY2: digits cleared to 0, go ENTRY0.
- COMMIT (exactly one cycle): {dig_hi,dig_lo} compared against every CAND_CODES entry. Match i → cnt[i]++, otherwise null++. total++ in both cases. vote_ack=1, digits cleared, go ENTRY0.
- Priority for simultaneous pulses in the same cycle: finalize > correct > confirm > digit.
- finalize_i in any ENTRY state discards the partial entry → TALLY. In COMMIT it is ignored, so the vote always completes.
- TALLY: scan index 0..N_CAND-1, one candidate per cycle. Initial values best=0, best_idx=0, tie=1.
  - cnt>best: best=cnt, best_idx=i, tie=0.
  - cnt==best: tie=1.
  - After the last candidate → RESULTS.
- RESULTS: results_vld=1; winner_idx and tie are frozen. All inputs except rd_idx are ignored. The core leaves RESULTS only on reset.
- Counters saturate at 2^CNT_W−1 and set ovf. ovf clears only on reset.
- Readout map: rd_idx<N_CAND → cnt[rd_idx]; N_CAND → null; N_CAND+1 → total; N_CAND+2 → blank (0 if the blank feature is absent); larger values → 0. The readout works in every state.

## Timing
- Reset values: state ENTRY0, all counters 0, dig_hi=dig_lo=0, vote_ack=0, rd_count=0, results_vld=0, winner_idx=0, tie=0, ovf=0.
- confirm_i sampled at edge t → COMMIT during cycle t..t+1, with vote_ack high. Counters are updated at edge t+1 and become visible on rd_count at edge t+2.
- Back-to-back votes: the next digit is accepted starting the cycle after COMMIT.
- finalize_i at edge t → results_vld rises at edge t+N_CAND+1.
- rd_count latency: 1 cycle from rd_idx.
- rst_n asserted mid-TALLY or mid-COMMIT: all state is cleared immediately and the partial vote is lost.

## Configuration
- URNA_BLANK_VOTE_EN defined:
  - Adds input blank_i (1-bit pulse), honoured only in ENTRY0 with priority just below correct_i.
  - blank_i → COMMIT, which increments the blank counter and total and asserts vote_ack.
  - Blank votes never affect the winner or tie.
- Undefined: no blank_i port, no blank counter, and rd_idx=N_CAND+2 reads 0.

## Structure
- Shared package urna_pkg: state enum, default CAND_CODES constant, readout-index offset constants (RD_NULL, RD_TOTAL, RD_BLANK).
- One natural sub-module, urna_sat_counter: a CNT_W-wide saturating incrementer with an overflow flag. It is instantiated per candidate and for null, total and blank.

## Test plan
- Keys 1,0, confirm → vote_ack one pulse; rd_idx=0 returns 1; rd_idx=N_CAND+1 (total) returns 1.
- Keys 9,9, confirm → null=1, all candidate counts 0.
- Keys 1, correct, then 5,1, confirm → cnt[3]=1, null=0.
- Three votes for code 13 and one for code 10, then finalize → results_vld exactly N_CAND+1 cycles later; winner_idx=1, tie=0.
- Two votes each for codes 10 and 17, then finalize → tie=1. Finalize with zero votes → tie=1.
- CNT_W=2, five votes for code 10 → cnt[0]=3, total=3, ovf=1.
- confirm_i and finalize_i in the same cycle in ENTRY2 → no vote counted; core enters TALLY.
